icache_refill_ctrl: RTL and testbench

- Sequences one I-cache line refill over the downstream AHB-Lite master port.
- Accepts a miss address from the cache core and issues a 4-beat WRAP4 read burst, critical word first.
- Tolerates slave wait states and error responses.
- Returns the critical word early and the assembled 128-bit line when the burst completes. It sits between the cache hit/miss logic and the memory-side AHB-Lite bus.

---
 rtl/icache_refill_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
//
// Refills one 16-byte I-cache line over an AHB-Lite master port. It accepts a
// miss address from the cache core and issues a 4-beat read burst. With
// CRIT_FIRST=1 the burst is WRAP4 and starts at the missed word. With
// CRIT_FIRST=0 it is INCR4 and starts at the line base. The first beat is
// returned early on crit_*, and the assembled line is returned on line_*.
// Slave wait states and two-cycle ERROR responses are tolerated.
//
// Parameters
//   CRIT_FIRST : 1 = WRAP4 starting at the miss word, 0 = INCR4 from line base
//   IDLE_GAP   : minimum extra idle cycles (0..3) spent in GAP after a burst
//
// Ports
//   hclk, hrstn            clock, asynchronous active-low reset
//   req_valid/req_addr     refill request from the cache core (held by core)
//   req_ready              controller idle, request is accepted on valid&ready
//   crit_valid/crit_data   one-cycle pulse with the first returned beat
//   line_valid             one-cycle pulse, line_data holds the complete line
//   line_err               one-cycle pulse, refill aborted by an ERROR response
//   line_addr/line_data    line base address and assembled line (word w at
//                          [32w+31:32w])
//   haddr/htrans/hburst/hsize/hwrite   AHB-Lite address phase (all registered)
//   hrdata/hready/hresp    AHB-Lite data phase response
// -----------------------------------------------------------------------------
module icache_refill_ctrl #(
    parameter int CRIT_FIRST = 1,
    parameter int IDLE_GAP   = 0
) (
    input  logic         hclk,
    input  logic         hrstn,
    input  logic         req_valid,
    input  logic [31:0]  req_addr,
    output logic         req_ready,
    output logic         crit_valid,
    output logic [31:0]  crit_data,
    output logic         line_valid,
    output logic         line_err,
    output logic [31:0]  line_addr,
    output logic [127:0] line_data,
    output logic [31:0]  haddr,
    output logic [1:0]   htrans,
    output logic [2:0]   hburst,
    output logic [2:0]   hsize,
    output logic         hwrite,
    input  logic [31:0]  hrdata,
    input  logic         hready,
    input  logic         hresp
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HBURST_INIT   = (CRIT_FIRST != 0) ? 3'b010 : 3'b011;
    localparam bit         USE_GAP       = (IDLE_GAP > 0);
    // GAP counts down to zero, so it is loaded with IDLE_GAP-1.
    localparam logic [1:0] GAP_INIT      = USE_GAP ? 2'(IDLE_GAP - 1) : 2'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_GAP
    } state_t;

    state_t         r_state;
    logic [31:0]    r_haddr;
    logic [1:0]     r_htrans;
    logic [2:0]     r_hburst;
    logic           r_req_ready;
    logic           r_crit_valid;
    logic [31:0]    r_crit_data;
    logic           r_line_valid;
    logic           r_line_err;
    logic [31:0]    r_line_addr;
    logic [127:0]   r_line_data;
    logic [1:0]     r_addr_cnt;   // address phases accepted so far
    logic [1:0]     r_beat_cnt;   // data beats captured so far
    logic           r_dphase;     // a data phase is outstanding on the bus
    logic [1:0]     r_dword;      // line word index of the outstanding beat
    logic           r_err;        // first ERROR cycle seen, waiting for second
    logic [1:0]     r_gap_cnt;

    logic           w_accept;
    logic [31:0]    w_start_addr;
    logic [31:0]    w_next_haddr;
    logic           w_err_first;

    assign w_accept     = req_valid && r_req_ready && (r_state == S_IDLE);
    assign w_start_addr = (CRIT_FIRST != 0) ? {req_addr[31:2], 2'b00}
                                            : {req_addr[31:4], 4'h0};
    // Word index increments modulo 4 so the address never leaves the line.
    assign w_next_haddr = {r_haddr[31:4], r_haddr[3:2] + 2'd1, 2'b00};
    // First cycle of the two-cycle ERROR response on an outstanding beat.
    assign w_err_first  = r_dphase && hresp && !hready && !r_err;

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            r_state      <= S_IDLE;
            r_haddr      <= 32'd0;
            r_htrans     <= HTRANS_IDLE;
            r_hburst     <= HBURST_INIT;
            r_req_ready  <= 1'b1;
            r_crit_valid <= 1'b0;
            r_crit_data  <= 32'd0;
            r_line_valid <= 1'b0;
            r_line_err   <= 1'b0;
            r_line_addr  <= 32'd0;
            r_line_data  <= 128'd0;
            r_addr_cnt   <= 2'd0;
            r_beat_cnt   <= 2'd0;
            r_dphase     <= 1'b0;
            r_dword      <= 2'd0;
            r_err        <= 1'b0;
            r_gap_cnt    <= 2'd0;
        end else begin
            r_crit_valid <= 1'b0;
            r_line_valid <= 1'b0;
            r_line_err   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_line_addr <= {req_addr[31:4], 4'h0};
                        r_addr_cnt  <= 2'd0;
                        r_beat_cnt  <= 2'd0;
                        r_dphase    <= 1'b0;
                        r_err       <= 1'b0;
                        r_haddr     <= w_start_addr;
                        r_htrans    <= HTRANS_NONSEQ;
                        r_state     <= S_ADDR;
                    end
                end

                S_ADDR, S_DATA: begin
                    if (r_err) begin
                        // Second ERROR cycle: the burst is abandoned here.
                        if (hready) begin
                            r_line_err <= 1'b1;
                            r_dphase   <= 1'b0;
                            r_err      <= 1'b0;
                            if (USE_GAP) begin
                                r_state   <= S_GAP;
                                r_gap_cnt <= GAP_INIT;
                            end else begin
                                r_state     <= S_IDLE;
                                r_req_ready <= 1'b1;
                            end
                        end
                    end else if (w_err_first) begin
                        // Cancel any remaining address phases immediately.
                        r_err    <= 1'b1;
                        r_htrans <= HTRANS_IDLE;
                        r_state  <= S_DATA;
                    end else if (hready) begin
                        // Data phase of the previously accepted address.
                        if (r_dphase) begin
                            r_line_data[{r_dword, 5'd0} +: 32] <= hrdata;
                            r_beat_cnt <= r_beat_cnt + 2'd1;
                            if (r_beat_cnt == 2'd0) begin
                                r_crit_valid <= 1'b1;
                                r_crit_data  <= hrdata;
                            end
                            if (r_beat_cnt == 2'd3) begin
                                r_line_valid <= 1'b1;
                                if (USE_GAP) begin
                                    r_state   <= S_GAP;
                                    r_gap_cnt <= GAP_INIT;
                                end else begin
                                    r_state     <= S_IDLE;
                                    r_req_ready <= 1'b1;
                                end
                            end
                        end

                        // Address phase currently on the bus is accepted and
                        // becomes the next data phase.
                        r_dphase <= 1'b0;
                        if (r_htrans != HTRANS_IDLE) begin
                            r_dphase   <= 1'b1;
                            r_dword    <= r_haddr[3:2];
                            r_addr_cnt <= r_addr_cnt + 2'd1;
                            if (r_addr_cnt == 2'd3) begin
                                r_htrans <= HTRANS_IDLE;
                                r_state  <= S_DATA;
                            end else begin
                                r_haddr  <= w_next_haddr;
                                r_htrans <= HTRANS_SEQ;
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (r_gap_cnt == 2'd0) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 2'd1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign crit_valid = r_crit_valid;
    assign crit_data  = r_crit_data;
    assign line_valid = r_line_valid;
    assign line_err   = r_line_err;
    assign line_addr  = r_line_addr;
    assign line_data  = r_line_data;
    assign haddr      = r_haddr;
    assign htrans     = r_htrans;
    assign hburst     = r_hburst;
    assign hsize      = 3'b010;
    assign hwrite     = 1'b0;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for icache_refill_ctrl. Two instances are built: one WRAP4 with no
// idle gap, one INCR4 with IDLE_GAP=2. An AHB slave model inside the bench
// answers each instance, and a line/timing reference computed from the burst
// rules is compared against what the controller returns.
// -----------------------------------------------------------------------------
module tb_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         hrstn;
    logic         req_valid  [2];
    logic [31:0]  req_addr   [2];
    logic         req_ready  [2];
    logic         crit_valid [2];
    logic [31:0]  crit_data  [2];
    logic         line_valid [2];
    logic         line_err   [2];
    logic [31:0]  line_addr  [2];
    logic [127:0] line_data  [2];
    logic [31:0]  haddr      [2];
    logic [1:0]   htrans     [2];
    logic [2:0]   hburst     [2];
    logic [2:0]   hsize      [2];
    logic         hwrite     [2];
    logic [31:0]  hrdata     [2];
    logic         hready     [2];
    logic         hresp      [2];

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [31:0]  salt     = 32'd0;

    initial forever #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        icache_refill_ctrl #(
            .CRIT_FIRST (gi == 0 ? 1 : 0),
            .IDLE_GAP   (gi == 0 ? 0 : 2)
        ) u_dut (
            .hclk       (clk),
            .hrstn      (hrstn),
            .req_valid  (req_valid[gi]),
            .req_addr   (req_addr[gi]),
            .req_ready  (req_ready[gi]),
            .crit_valid (crit_valid[gi]),
            .crit_data  (crit_data[gi]),
            .line_valid (line_valid[gi]),
            .line_err   (line_err[gi]),
            .line_addr  (line_addr[gi]),
            .line_data  (line_data[gi]),
            .haddr      (haddr[gi]),
            .htrans     (htrans[gi]),
            .hburst     (hburst[gi]),
            .hsize      (hsize[gi]),
            .hwrite     (hwrite[gi]),
            .hrdata     (hrdata[gi]),
            .hready     (hready[gi]),
            .hresp      (hresp[gi])
        );
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Memory contents seen by the slave; salt=0 gives 0xA0 + word index.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (salt == 32'd0) return 32'h000000A0 + 32'(a[3:2]);
        return (a * 32'h9E3779B1) ^ salt;
    endfunction

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    // One refill on instance d. wb/wn: wn wait states on beat wb.
    // eb: beat that gets an ERROR response (-1 = none). hold: keep req_valid.
    task automatic run_refill(input int d, input logic [31:0] addr, input int wb,
                              input int wn, input int eb, input bit hold);
        logic [31:0]  base;
        logic [1:0]   sw, w;
        logic [31:0]  exp_seq [4];
        logic [127:0] exp_line, exp_addrs, got_addrs, got_line;
        logic [7:0]   got_trans;
        logic [31:0]  exp_crit, got_crit, got_laddr, dp_a;
        logic [2:0]   exp_burst;
        logic [1:0]   err2_trans;
        int cyc, guard, n_acc, n_crit, n_line, n_err, n_nonseq, n_bad_trans;
        int n_bad_burst, t_crit, t_line, t_err, t_done, ready_delay, dp_k;
        int waits_left, err_ph, tail_idle, exp_t_crit, exp_t_err;
        bit dp_v, finished;

        base      = {addr[31:4], 4'h0};
        sw        = (d == 0) ? addr[3:2] : 2'd0;
        exp_burst = (d == 0) ? 3'b010 : 3'b011;
        exp_line  = '0;
        exp_addrs = '0;
        for (int k = 0; k < 4; k++) begin
            w = sw + 2'(k);
            exp_seq[k] = base | {28'd0, w, 2'b00};
            exp_line[{w, 5'd0} +: 32] = mem_rd(exp_seq[k]);
            exp_addrs[32*k +: 32] = exp_seq[k];
        end
        exp_crit = mem_rd(exp_seq[0]);

        got_addrs = '0; got_trans = '0; got_line = '0; got_crit = '0; got_laddr = '0;
        err2_trans = 2'b11; dp_a = '0;
        n_acc = 0; n_crit = 0; n_line = 0; n_err = 0; n_nonseq = 0; n_bad_trans = 0;
        n_bad_burst = 0; t_crit = -1; t_line = -1; t_err = -1; t_done = -1;
        ready_delay = -1; dp_k = 0; waits_left = wn; err_ph = 0; tail_idle = 0;
        dp_v = 0; finished = 0;

        $display("refill dut%0d addr=%08h wait=%0d@beat%0d err_beat=%0d hold=%0d",
                 d, addr, wn, wb, eb, hold);

        guard = 0;
        while (!req_ready[d] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_req", 128'(req_ready[d]), 128'(1));

        hready[d] = 1'b1; hresp[d] = 1'b0;
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        @(negedge clk);
        cyc = 1;
        if (!hold) req_valid[d] = 1'b0;

        while (cyc <= 60 && !finished) begin
            if (err_ph == 1) err2_trans = htrans[d];
            if (err_ph >= 1 && htrans[d] != 2'b00) n_bad_trans++;
            if (htrans[d] == 2'b10) n_nonseq++;
            if (htrans[d] != 2'b00 && hburst[d] != exp_burst) n_bad_burst++;
            if (n_acc > 0 && htrans[d] == 2'b00) tail_idle++;
            if (crit_valid[d]) begin n_crit++; t_crit = cyc; got_crit = crit_data[d]; end
            if (line_valid[d]) begin
                n_line++; t_line = cyc; got_line = line_data[d]; got_laddr = line_addr[d];
            end
            if (line_err[d]) begin n_err++; t_err = cyc; got_laddr = line_addr[d]; end
            if ((line_valid[d] || line_err[d]) && t_done < 0) t_done = cyc;

            if (t_done >= 0 && req_ready[d]) begin
                finished = 1;
                ready_delay = cyc - t_done;
            end else begin
                hresp[d] = 1'b0; hready[d] = 1'b1; hrdata[d] = $urandom;
                if (err_ph == 1) begin
                    hresp[d] = 1'b1;
                    err_ph = 2;
                end else if (dp_v) begin
                    if (dp_k == wb && waits_left > 0) begin
                        hready[d] = 1'b0;
                        waits_left--;
                    end else if (dp_k == eb) begin
                        hresp[d] = 1'b1; hready[d] = 1'b0;
                        err_ph = 1;
                    end else begin
                        hrdata[d] = mem_rd(dp_a);
                    end
                end
                if (hready[d]) begin
                    if (htrans[d] != 2'b00) begin
                        if (n_acc < 4) begin
                            got_addrs[32*n_acc +: 32] = haddr[d];
                            got_trans[2*n_acc +: 2]   = htrans[d];
                        end
                        dp_v = 1; dp_a = haddr[d]; dp_k = n_acc;
                        n_acc++;
                    end else begin
                        dp_v = 0;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        hready[d] = 1'b1; hresp[d] = 1'b0;
        req_valid[d] = hold;

        chk("finished", 128'(finished), 128'(1));
        chk("nonseq_count", 128'(n_nonseq), 128'(1));
        chk("line_addr", 128'(got_laddr), 128'(base));
        chk("ready_delay", 128'(ready_delay), 128'(gap_of(d)));
        chk("hburst_bad", 128'(n_bad_burst), 128'(0));
        if (gap_of(d) > 0) chk("idle_gap", 128'(tail_idle >= gap_of(d)), 128'(1));
        if (eb < 0) begin
            exp_t_crit = 3 + ((wb == 0) ? wn : 0);
            chk("addr_count", 128'(n_acc), 128'(4));
            chk("haddr_seq", got_addrs, exp_addrs);
            chk("htrans_seq", 128'(got_trans), 128'(8'hFE));
            chk("crit_count", 128'(n_crit), 128'(1));
            chk("crit_time", 128'(t_crit), 128'(exp_t_crit));
            chk("crit_data", 128'(got_crit), 128'(exp_crit));
            chk("line_count", 128'(n_line), 128'(1));
            chk("line_time", 128'(t_line), 128'(6 + wn));
            chk("line_data", got_line, exp_line);
            chk("err_count", 128'(n_err), 128'(0));
        end else begin
            exp_t_err = 4 + eb + ((wb < eb) ? wn : 0);
            chk("err_count", 128'(n_err), 128'(1));
            chk("err_time", 128'(t_err), 128'(exp_t_err));
            chk("line_after_err", 128'(n_line), 128'(0));
            chk("crit_count_err", 128'(n_crit), 128'((eb > 0) ? 1 : 0));
            chk("htrans_err2", 128'(err2_trans), 128'(0));
            chk("htrans_after_err", 128'(n_bad_trans), 128'(0));
        end
    endtask

    initial begin
        int pulses;
        int d, wb, wn, eb;
        logic [31:0] a;

        hrstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_addr[i] = '0;
            hrdata[i] = '0; hready[i] = 1'b1; hresp[i] = 1'b0;
        end
        repeat (3) @(negedge clk);

        for (int i = 0; i < 2; i++) begin
            chk("rst_htrans", 128'(htrans[i]), 128'(0));
            chk("rst_haddr", 128'(haddr[i]), 128'(0));
            chk("rst_hburst", 128'(hburst[i]), 128'((i == 0) ? 3'b010 : 3'b011));
            chk("rst_req_ready", 128'(req_ready[i]), 128'(1));
            chk("rst_pulses", 128'({crit_valid[i], line_valid[i], line_err[i]}), 128'(0));
            chk("rst_line_addr", 128'(line_addr[i]), 128'(0));
            chk("rst_line_data", line_data[i], 128'(0));
            chk("rst_crit_data", 128'(crit_data[i]), 128'(0));
            chk("hsize_hwrite", 128'({hsize[i], hwrite[i]}), 128'(4'b0100));
        end
        hrstn = 1'b1;
        @(negedge clk);

        // Directed cases
        salt = 32'd0;
        run_refill(0, 32'h0000_1008, 0, 0, -1, 0);
        run_refill(0, 32'h0000_1008, 1, 2, -1, 0);
        run_refill(1, 32'h0000_2004, 0, 0, -1, 0);
        run_refill(0, 32'h0000_1008, 0, 0, 2, 0);
        run_refill(0, 32'h0000_1008, 0, 0, -1, 0);
        run_refill(0, 32'h0000_1004, 0, 0, 0, 0);
        run_refill(0, 32'h0000_100C, 0, 0, 3, 0);
        // Back-to-back with the request held high on the gapped instance
        run_refill(1, 32'h0000_3010, 0, 0, -1, 1);
        run_refill(1, 32'h0000_3010, 2, 1, -1, 1);
        run_refill(1, 32'h0000_3010, 0, 0, -1, 0);

        // Reset asserted during beat 1 of a burst on instance 0
        req_valid[0] = 1'b1; req_addr[0] = 32'h0000_4008;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        hrdata[0] = mem_rd(32'h0000_4008);
        @(negedge clk);
        hrdata[0] = mem_rd(32'h0000_400C);
        hrstn = 1'b0;
        #1;
        chk("midrst_htrans", 128'(htrans[0]), 128'(0));
        chk("midrst_req_ready", 128'(req_ready[0]), 128'(1));
        chk("midrst_haddr", 128'(haddr[0]), 128'(0));
        @(negedge clk);
        @(negedge clk);
        hrstn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (crit_valid[0] || line_valid[0] || line_err[0] || htrans[0] != 2'b00) pulses++;
        end
        chk("post_rst_activity", 128'(pulses), 128'(0));
        chk("post_rst_ready", 128'(req_ready[0]), 128'(1));
        run_refill(0, 32'h0000_4008, 0, 0, -1, 0);

        // Randomized refills
        for (int n = 0; n < 24; n++) begin
            salt = $urandom | 32'h1;
            d  = int'($urandom_range(0, 1));
            a  = $urandom;
            wb = int'($urandom_range(0, 3));
            wn = int'($urandom_range(0, 3));
            eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            if (eb >= 0 && wb >= eb) wn = 0;
            run_refill(d, a, wb, wn, eb, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
